// File: rtl/mem_responder_4c.sv
// mem_responder_4c: multi-cycle single-port 16-bit memory with a fixed-latency,
// fully pipelined read path and same-cycle write commit.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to add the misaligned_err output,
// which flags requests whose byte address has bit 0 set. Without the macro the
// port does not exist and addr[0] is ignored.
module mem_responder_4c #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 4,
  parameter int WORDS   = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic              busy
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misaligned_err
`endif
);

  localparam int MEM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LAST   = LATENCY - 1;

  // Storage array and request decode.
  logic [15:0]       mem [WORDS];
  logic [ADDR_W-2:0] word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              rd_accept;
  logic              wr_accept;

  assign word_idx  = addr[ADDR_W-1:1];
  // Out-of-range word indices wrap modulo the array depth.
  assign mem_idx   = MEM_AW'(32'(word_idx) % WORDS);
  // Requests arriving in a reset cycle are dropped, writes included.
  assign rd_accept = enable & ~wr & ~rst;
  assign wr_accept = enable &  wr & ~rst;

  // Read pipeline: per-stage valid bit and captured data word.
  logic        valid_q  [LATENCY];
  logic [15:0] data_q   [LATENCY];
  logic        in_valid [LATENCY];
  logic [15:0] in_data  [LATENCY];

  // Array write port; contents survive reset.
  // NOTE: memory arrays are never reset -- a reset loop over every word would
  // prevent RAM inference and the contents must persist across reset anyway.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[mem_idx] <= data_in;
    end
  end

  // Stage inputs: stage 0 captures the array word at issue, later stages shift.
  // NOTE: every signal driven here gets a value before any condition, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    in_valid[0] = rd_accept;
    in_data[0]  = mem[mem_idx];
    for (int i = 1; i < LATENCY; i++) begin
      in_valid[i] = valid_q[i-1];
      in_data[i]  = data_q[i-1];
    end
  end

  // Pipeline registers; the last stage only loads on a valid read so the
  // output word holds between responses.
  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i] <= in_valid[i];
        if (i < LAST || in_valid[i]) begin
          data_q[i] <= in_data[i];
        end
      end
    end
  end

  // Busy is the OR of the registered stage valids only.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | valid_q[i];
    end
  end

  assign data_out   = data_q[LAST];
  assign data_valid = valid_q[LAST];

`ifdef MEM_ALIGN_CHECK_EN
  // Alignment-error tracking: one bit per read stage, one for writes.
  logic err_q    [LATENCY];
  logic in_err   [LATENCY];
  logic wr_err_q;

  // Error bit follows its read down the pipeline.
  always_comb begin
    in_err[0] = rd_accept & addr[0];
    for (int i = 1; i < LATENCY; i++) begin
      in_err[i] = err_q[i-1];
    end
  end

  // Error registers; write errors report the cycle after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        err_q[i] <= 1'b0;
      end
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        err_q[i] <= in_err[i];
      end
      wr_err_q <= wr_accept & addr[0];
    end
  end

  assign misaligned_err = (valid_q[LAST] & err_q[LAST]) | wr_err_q;
`else
  // Without alignment checking the byte-select bit has no function.
  logic unused_addr_lsb;
  assign unused_addr_lsb = addr[0];
`endif

endmodule
